fp_1d5_mul_normalize_pipe: RTL

Final stage of the inverse-square-root Newton iteration. It consumes the Q1.26 correction factor M_sub (1.5 - x*y^2/2) and the delayed estimate y from the 1.5-subtract stage, and computes y_new = y * M_sub. The result is normalized, rounded and repacked as a sign-less 31-bit float. It is a 2-stage pipeline with the same valid/ready/backprn/error side-band as the neighbouring stages, and its output feeds the next iteration or the result register.

---
 rtl/fp_1d5_mul_normalize_pipe.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fp_1d5_mul_normalize_pipe.sv
// fp_1d5_mul_normalize_pipe
//   Last step of the inverse-square-root Newton iteration: y_new = y * M_sub,
//   then normalize, round half-up and repack as a sign-less 31-bit float.
//   Two register stages; both advance only when backprn=1.
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   valid          M_sub / float_in_delay / error_in carry an item
//   M_sub          unsigned Q1.26 factor (bits 2:0 are round bits)
//   float_in_delay y estimate: [30:23] biased exponent, [22:0] fraction
//   error_in       upstream error flag, travels with the item
//   backprn        1 = advance, 0 = hold every register
//   float_out      y_new, same format as float_in_delay
//   ready          float_out / error_out hold a valid item
//   error_out      error flag for the item on float_out
module fp_1d5_mul_normalize_pipe #(
  parameter int EXP_SHIFT   = 23,
  parameter int ROUND_SHIFT = 3,
  parameter int EXP_W       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid,
  input  logic [EXP_SHIFT+ROUND_SHIFT:0] M_sub,
  input  logic [EXP_W+EXP_SHIFT-1:0]   float_in_delay,
  input  logic                         error_in,
  input  logic                         backprn,
  output logic [EXP_W+EXP_SHIFT-1:0]   float_out,
  output logic                         ready,
  output logic                         error_out
);

  localparam int FW = EXP_SHIFT;                 // fraction width
  localparam int MW = EXP_SHIFT + ROUND_SHIFT + 1; // M_sub width
  localparam int PW = FW + 1 + MW;               // product width
  localparam int XW = EXP_W + 2;                 // exponent working width
  localparam int OW = EXP_W + FW;                // float width

  // ---------------- stage 1: multiply ----------------
  logic [PW-1:0]    prod_c;
  logic             m_err_c;

  logic [PW-1:0]    s1_prod;
  logic [EXP_W-1:0] s1_exp;
  logic             s1_valid;
  logic             s1_err_in;
  logic             s1_err_m;

  assign prod_c  = PW'({1'b1, float_in_delay[FW-1:0]}) * PW'(M_sub);
  assign m_err_c = (M_sub[MW-1 -: 2] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_prod   <= '0;
      s1_exp    <= '0;
      s1_valid  <= 1'b0;
      s1_err_in <= 1'b0;
      s1_err_m  <= 1'b0;
    end else if (backprn) begin
      if (valid) begin
        s1_prod   <= prod_c;
        s1_exp    <= float_in_delay[OW-1:FW];
        s1_valid  <= 1'b1;
        s1_err_in <= error_in;
        s1_err_m  <= m_err_c;
      end else begin
        s1_valid  <= 1'b0;
        s1_err_in <= 1'b0;
        s1_err_m  <= 1'b0;
      end
    end
  end

  // ---------------- stage 2: normalize / round / pack ----------------
  logic [FW-1:0]    frac_raw;
  logic             rnd;
  logic             sticky_unused;
  logic [XW-1:0]    exp_b;
  logic [FW:0]      rounded;
  logic [XW-1:0]    exp_r;
  logic [EXP_W-1:0] exp_field;
  logic             ovf;
  logic             unf;
  logic [OW-1:0]    result;

  // exp_b carries the exponent biased by +1 so the y_exp-1 case never wraps;
  // the field value is exp_r-1, and the range limits shift by one accordingly.
  // Sticky is formed but ties round up without it.
  always_comb begin
    frac_raw      = '0;
    rnd           = 1'b0;
    sticky_unused = 1'b0;
    exp_b         = '0;
    if (s1_prod[PW-1]) begin
      frac_raw      = s1_prod[PW-2 -: FW];
      rnd           = s1_prod[PW-2-FW];
      sticky_unused = |s1_prod[PW-3-FW:0];
      exp_b         = {2'b00, s1_exp} + XW'(2);
    end else if (s1_prod[PW-2]) begin
      frac_raw      = s1_prod[PW-3 -: FW];
      rnd           = s1_prod[PW-3-FW];
      sticky_unused = |s1_prod[PW-4-FW:0];
      exp_b         = {2'b00, s1_exp} + XW'(1);
    end else begin
      frac_raw      = s1_prod[PW-4 -: FW];
      rnd           = s1_prod[PW-4-FW];
      sticky_unused = |s1_prod[PW-5-FW:0];
      exp_b         = {2'b00, s1_exp};
    end

    rounded   = {1'b0, frac_raw} + (FW+1)'(rnd);
    exp_r     = exp_b + XW'(rounded[FW]);
    exp_field = exp_r[EXP_W-1:0] - EXP_W'(1);
    ovf       = (exp_r >= XW'(2**EXP_W));
    unf       = (exp_r <= XW'(1));

    if (ovf) begin
      result = {{EXP_W{1'b1}}, {FW{1'b0}}};
    end else if (unf) begin
      result = '0;
    end else begin
      result = {exp_field, rounded[FW-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      float_out <= '0;
      ready     <= 1'b0;
      error_out <= 1'b0;
    end else if (backprn) begin
      ready <= s1_valid;
      if (s1_valid) begin
        float_out <= result;
        error_out <= s1_err_in | s1_err_m | ovf | unf;
      end else begin
        error_out <= 1'b0;
      end
    end
  end

endmodule
